// File: rtl/ram_seq_ctrl.sv
// ram_seq_ctrl: fills an asynchronous-read single-port RAM from a byte stream
// at consecutive addresses from 0 upward, then dumps the stored entries back
// in write order on request and empties itself for the next fill.
//
// Optional feature macro: RAM_SEQ_LAST_EN adds out_last, which marks the final
// dumped entry. Without it the port and its logic are absent.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   in_data/valid/ready write stream (valid/ready)
//   dump_start          single-cycle request to read out stored entries
//   out_data/valid/ready read stream; out_data passes ram_rdata through
//   ram_addr/wdata/wr   RAM write port and shared (read) address
//   ram_rdata           RAM asynchronous read data
//   count, full, busy   stored entries, buffer full, dump in progress
//   out_last            (RAM_SEQ_LAST_EN only) final dumped entry marker
module ram_seq_ctrl #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  dump_start,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  ram_wr,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  busy
`ifdef RAM_SEQ_LAST_EN
  ,
  output logic                  out_last
`endif
);

  localparam int unsigned CNT_W = ADDR_WIDTH + 1;
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_DUMP = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [ADDR_WIDTH-1:0] rptr_q,  rptr_d;

  logic                  full_w;
  logic                  wr_en;
  logic                  last_hit;
  logic [CNT_W-1:0]      last_idx;

  // State, entry count and read pointer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
      rptr_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rptr_q  <= rptr_d;
    end
  end

  assign full_w   = (count_q == CNT_W'(DEPTH));
  // Index of the final stored entry; only meaningful while count_q != 0 (DUMP).
  assign last_idx = count_q - CNT_W'(1);
  assign last_hit = ({1'b0, rptr_q} == last_idx);

  // Next-state, handshake and RAM port control.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    rptr_d   = rptr_q;
    in_ready = 1'b0;
    wr_en    = 1'b0;
    ram_addr = count_q[ADDR_WIDTH-1:0];

    case (state_q)
      S_IDLE: begin
        in_ready = !full_w;
        wr_en    = in_valid && !full_w;
        count_d  = count_q + CNT_W'(wr_en);
        // A same-cycle write is counted before deciding whether there is data to dump.
        if (dump_start && (count_d != '0)) begin
          state_d = S_DUMP;
          rptr_d  = '0;
        end
      end
      S_DUMP: begin
        ram_addr = rptr_q;
        if (out_ready) begin
          if (last_hit) begin
            state_d = S_IDLE;
            count_d = '0;
            rptr_d  = '0;
          end else begin
            rptr_d = rptr_q + ADDR_WIDTH'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign ram_wr    = wr_en;
  assign ram_wdata = in_data;
  assign out_data  = ram_rdata;
  assign out_valid = (state_q == S_DUMP);
  assign busy      = (state_q == S_DUMP);
  assign count     = count_q;
  assign full      = full_w;

`ifdef RAM_SEQ_LAST_EN
  assign out_last  = (state_q == S_DUMP) && last_hit;
`endif

endmodule

// File: tb/tb_ram_seq_ctrl.sv
module tb_ram_seq_ctrl;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic          dump_start;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_wr;
  logic [DW-1:0] ram_rdata;
  logic [AW:0]   count;
  logic          full;
  logic          busy;
`ifdef RAM_SEQ_LAST_EN
  logic          out_last;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0] mem [1<<AW];

  always #5 clk = ~clk;

  // Behavioural ram_ip: synchronous write, asynchronous read at the same address.
  always @(posedge clk) if (ram_wr) mem[ram_addr] <= ram_wdata;
  assign ram_rdata = mem[ram_addr];

  ram_seq_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .dump_start(dump_start),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wr(ram_wr),
    .ram_rdata(ram_rdata),
    .count(count), .full(full), .busy(busy)
`ifdef RAM_SEQ_LAST_EN
    , .out_last(out_last)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic last_chk(input string tag, input logic exp);
`ifdef RAM_SEQ_LAST_EN
    chk(tag, 32'(out_last), 32'(exp));
`else
    if (exp === 1'bx) $display("unused %s", tag);
`endif
  endtask

  task automatic write(input logic [DW-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    #1;
    chk("wr_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic pulse_dump();
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b1; in_data = '0; in_valid = 1'b0; dump_start = 1'b0; out_ready = 1'b1;
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    last_chk("rst_last", 1'b0);

    // Fill 3 then dump
    write(8'hA1); write(8'hB2); write(8'hC3);
    chk("f3_count", 32'(count), 32'd3);
    pulse_dump();
    chk("f3_valid0", 32'(out_valid), 32'd1);
    chk("f3_busy0", 32'(busy), 32'd1);
    chk("f3_in_ready", 32'(in_ready), 32'd0);
    chk("f3_data0", 32'(out_data), 32'hA1);
    last_chk("f3_last0", 1'b0);
    tick();
    chk("f3_data1", 32'(out_data), 32'hB2);
    last_chk("f3_last1", 1'b0);
    tick();
    chk("f3_data2", 32'(out_data), 32'hC3);
    chk("f3_busy2", 32'(busy), 32'd1);
    last_chk("f3_last2", 1'b1);
    tick();
    chk("f3_busy_end", 32'(busy), 32'd0);
    chk("f3_valid_end", 32'(out_valid), 32'd0);
    chk("f3_count_end", 32'(count), 32'd0);
    last_chk("f3_last_end", 1'b0);

    // Empty dump is ignored
    pulse_dump();
    chk("empty_valid", 32'(out_valid), 32'd0);
    chk("empty_busy", 32'(busy), 32'd0);
    chk("empty_count", 32'(count), 32'd0);

    // Full buffer, 17th write held off
    for (int i = 0; i < 16; i++) write(8'(i));
    chk("full_flag", 32'(full), 32'd1);
    chk("full_count", 32'(count), 32'd16);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1; in_data = 8'hEE;
    #1;
    chk("full_no_wr", 32'(ram_wr), 32'd0);
    tick();
    in_valid = 1'b0;
    chk("full_count_hold", 32'(count), 32'd16);
    chk("full_mem0_kept", 32'(mem[0]), 32'h00);
    pulse_dump();
    for (int i = 0; i < 16; i++) begin
      chk("full_dump_data", 32'(out_data), 32'(i));
      chk("full_dump_valid", 32'(out_valid), 32'd1);
      tick();
    end
    chk("full_drained_busy", 32'(busy), 32'd0);
    chk("full_drained_count", 32'(count), 32'd0);
    chk("full_drained_full", 32'(full), 32'd0);

    // Backpressure
    write(8'h11); write(8'h22);
    out_ready = 1'b0;
    pulse_dump();
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold_data", 32'(out_data), 32'h11);
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_addr", 32'(ram_addr), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_data", 32'(out_data), 32'h11);
    tick();
    chk("bp_data1", 32'(out_data), 32'h22);
    last_chk("bp_last1", 1'b1);
    tick();
    chk("bp_done", 32'(busy), 32'd0);

    // Simultaneous write and dump_start
    write(8'h55);
    in_valid = 1'b1; in_data = 8'h66; dump_start = 1'b1;
    #1;
    chk("sim_wr", 32'(ram_wr), 32'd1);
    tick();
    in_valid = 1'b0; dump_start = 1'b0;
    #1;
    chk("sim_count", 32'(count), 32'd2);
    chk("sim_data0", 32'(out_data), 32'h55);
    tick();
    chk("sim_data1", 32'(out_data), 32'h66);
    tick();
    chk("sim_done", 32'(out_valid), 32'd0);
    chk("sim_count_end", 32'(count), 32'd0);

    // Reset mid-dump, then a fresh write lands at address 0
    write(8'h01); write(8'h02); write(8'h03); write(8'h04);
    pulse_dump();
    chk("rmd_data0", 32'(out_data), 32'h01);
    tick();
    chk("rmd_data1", 32'(out_data), 32'h02);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("rmd_valid", 32'(out_valid), 32'd0);
    chk("rmd_count", 32'(count), 32'd0);
    chk("rmd_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_data = 8'h77;
    #1;
    chk("rmd_addr", 32'(ram_addr), 32'd0);
    chk("rmd_wr", 32'(ram_wr), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("rmd_mem0", 32'(mem[0]), 32'h77);
    chk("rmd_count1", 32'(count), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
